// File: rtl/dir_lock_arbiter_pkg.sv
// Shared types, parameter defaults and width helper for the direction-lock arbiter.
package dir_lock_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_LOCKED  = 2'd1,
      ST_RELEASE = 2'd2
   } state_t;

   localparam int unsigned N_CH_DEF     = 2;
   localparam int unsigned ID_W_DEF     = 1;
   localparam int unsigned HOLD_W_DEF   = 4;
   localparam int unsigned HOLD_MAX_DEF = 15;

   // ceil(log2(n)), never below 1 so a 2-channel build still has a 1-bit id
   function automatic int unsigned id_width(input int unsigned n);
      int unsigned w;
      w = 1;
      while ((32'd1 << w) < n) w = w + 1;
      return w;
   endfunction

endpackage

// File: rtl/dir_lock_arbiter_rr_pick.sv
// Combinational round-robin picker: first eligible channel at or above rr_ptr, wrapping.
module dir_lock_arbiter_rr_pick
   import dir_lock_arbiter_pkg::*;
#(
   parameter int unsigned N_CH = N_CH_DEF,
   parameter int unsigned ID_W = ID_W_DEF
) (
   input  logic [N_CH-1:0] eligible,
   input  logic [ID_W-1:0] rr_ptr,
   output logic            valid,
   output logic [ID_W-1:0] winner,
   output logic [N_CH-1:0] onehot
);

   localparam logic [ID_W:0] N_VAL = (ID_W+1)'(N_CH);

   logic [N_CH-1:0] rotated;
   logic [N_CH-1:0] scan;
   logic [ID_W:0]   offset;
   logic [ID_W:0]   sum;

   always_comb begin
      // rotate so bit 0 is the channel at rr_ptr; the first set bit is the offset
      rotated = N_CH'({eligible, eligible} >> rr_ptr);
      scan    = rotated;
      valid   = 1'b0;
      offset  = '0;
      for (int unsigned i = 0; i < N_CH; i++) begin
         if (!valid && scan[0]) begin
            valid  = 1'b1;
            offset = (ID_W+1)'(i);
         end
         scan = scan >> 1;
      end
      sum = {1'b0, rr_ptr} + offset;
      if (sum >= N_VAL) sum = sum - N_VAL;
      winner = sum[ID_W-1:0];
      onehot = valid ? ({{(N_CH-1){1'b0}}, 1'b1} << winner) : '0;
   end

endmodule

// File: rtl/dir_lock_arbiter.sv
// N-channel exclusive lock with round-robin arbitration, hold timeout and re-request mask.
module dir_lock_arbiter
   import dir_lock_arbiter_pkg::*;
#(
   parameter int unsigned N_CH     = N_CH_DEF,
   parameter int unsigned ID_W     = ID_W_DEF,
   parameter int unsigned HOLD_W   = HOLD_W_DEF,
   parameter int unsigned HOLD_MAX = HOLD_MAX_DEF
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [N_CH-1:0] req,
   output logic [N_CH-1:0] grant,
   output logic [ID_W-1:0] lock_id,
   output logic            idle,
   output logic            timeout
);

   if (N_CH < 2) begin : g_bad_n_ch
      $error("dir_lock_arbiter: N_CH must be at least 2");
   end
   if (ID_W != id_width(N_CH)) begin : g_bad_id_w
      $error("dir_lock_arbiter: ID_W must equal ceil(log2(N_CH))");
   end
   if (HOLD_MAX >= (64'd1 << HOLD_W)) begin : g_bad_hold
      $error("dir_lock_arbiter: HOLD_MAX must fit in HOLD_W bits");
   end

   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((HOLD_MAX == 0) ? 0 : HOLD_MAX - 1);
   localparam logic [ID_W-1:0]   LAST_ID   = ID_W'(N_CH - 1);

   state_t            state, state_n;
   logic [N_CH-1:0]   grant_n, mask, mask_n;
   logic [ID_W-1:0]   lock_id_n, rr_ptr, rr_ptr_n;
   logic [HOLD_W-1:0] hold_cnt, hold_n;
   logic              idle_n, timeout_n;
   logic              pick_valid;
   logic [ID_W-1:0]   pick_id;
   logic [N_CH-1:0]   pick_onehot;
   logic              owner_req;

   dir_lock_arbiter_rr_pick #(
      .N_CH (N_CH),
      .ID_W (ID_W)
   ) u_rr_pick (
      .eligible (req & ~mask),
      .rr_ptr   (rr_ptr),
      .valid    (pick_valid),
      .winner   (pick_id),
      .onehot   (pick_onehot)
   );

   // grant is one-hot on the owner while locked, so this is req[owner]
   assign owner_req = |(req & grant);

   always_comb begin
      state_n   = state;
      grant_n   = '0;
      lock_id_n = '0;
      timeout_n = 1'b0;
      rr_ptr_n  = rr_ptr;
      hold_n    = hold_cnt;
      mask_n    = mask & req;
      unique case (state)
         ST_IDLE: begin
            if (pick_valid) begin
               state_n   = ST_LOCKED;
               grant_n   = pick_onehot;
               lock_id_n = pick_id;
               hold_n    = '0;
               rr_ptr_n  = (pick_id == LAST_ID) ? '0 : pick_id + ID_W'(1);
            end
         end
         ST_LOCKED: begin
            if (!owner_req) begin
               state_n = ST_RELEASE;
            end else if (HOLD_MAX != 0 && hold_cnt == HOLD_LAST) begin
               state_n   = ST_RELEASE;
               timeout_n = 1'b1;
               mask_n    = mask_n | grant;
            end else begin
               grant_n   = grant;
               lock_id_n = lock_id;
               if (hold_cnt != '1) hold_n = hold_cnt + HOLD_W'(1);
            end
         end
         ST_RELEASE: state_n = ST_IDLE;
         default:    state_n = ST_IDLE;
      endcase
      idle_n = (state_n == ST_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         grant    <= '0;
         lock_id  <= '0;
         idle     <= 1'b1;
         timeout  <= 1'b0;
         rr_ptr   <= '0;
         hold_cnt <= '0;
         mask     <= '0;
      end else begin
         state    <= state_n;
         grant    <= grant_n;
         lock_id  <= lock_id_n;
         idle     <= idle_n;
         timeout  <= timeout_n;
         rr_ptr   <= rr_ptr_n;
         hold_cnt <= hold_n;
         mask     <= mask_n;
      end
   end

endmodule

// File: tb/tb_dir_lock_arbiter.sv
// Bench for dir_lock_arbiter: a 2-channel untimed build and a 4-channel build with HOLD_MAX=4.
module tb_dir_lock_arbiter;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [1:0] req_a;
   logic [3:0] req_b;
   logic [1:0] grant_a;
   logic [0:0] lock_id_a;
   logic       idle_a, timeout_a;
   logic [3:0] grant_b;
   logic [1:0] lock_id_b;
   logic       idle_b, timeout_b;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   dir_lock_arbiter #(
      .N_CH     (2),
      .ID_W     (1),
      .HOLD_W   (4),
      .HOLD_MAX (0)
   ) u_dut_a (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (req_a),
      .grant   (grant_a),
      .lock_id (lock_id_a),
      .idle    (idle_a),
      .timeout (timeout_a)
   );

   dir_lock_arbiter #(
      .N_CH     (4),
      .ID_W     (2),
      .HOLD_W   (4),
      .HOLD_MAX (4)
   ) u_dut_b (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (req_b),
      .grant   (grant_b),
      .lock_id (lock_id_b),
      .idle    (idle_b),
      .timeout (timeout_b)
   );

   // owner < 0 means nobody holds the lock; gap marks the mandatory idle-less cycle after a release
   typedef struct {
      int       owner;
      bit       gap;
      int       held;
      int       ptr;
      bit [3:0] masked;
      bit       to;
   } mdl_t;

   mdl_t ma, mb;

   function automatic mdl_t mreset();
      mdl_t r;
      r.owner  = -1;
      r.gap    = 1'b0;
      r.held   = 0;
      r.ptr    = 0;
      r.masked = '0;
      r.to     = 1'b0;
      return r;
   endfunction

   function automatic mdl_t mstep(input mdl_t m, input logic [3:0] rq, input int n, input int hmax);
      mdl_t r;
      int   c;
      r    = m;
      r.to = 1'b0;
      for (int i = 0; i < n; i++) if (!rq[i]) r.masked[i] = 1'b0;
      if (m.gap) begin
         r.gap = 1'b0;
      end else if (m.owner < 0) begin
         for (int k = 0; k < n; k++) begin
            c = (m.ptr + k) % n;
            if (rq[c] && !r.masked[c]) begin
               r.owner = c;
               r.held  = 1;
               r.ptr   = (c + 1) % n;
               break;
            end
         end
      end else if (!rq[m.owner]) begin
         r.owner = -1;
         r.gap   = 1'b1;
      end else if (hmax != 0 && m.held == hmax) begin
         r.owner            = -1;
         r.gap              = 1'b1;
         r.to               = 1'b1;
         r.masked[m.owner]  = 1'b1;
      end else begin
         r.held = m.held + 1;
      end
      return r;
   endfunction

   function automatic logic [31:0] m_grant(input mdl_t m);
      return (m.owner >= 0) ? (32'd1 << m.owner) : 32'd0;
   endfunction

   function automatic logic [31:0] m_id(input mdl_t m);
      return (m.owner >= 0) ? 32'(m.owner) : 32'd0;
   endfunction

   function automatic logic [31:0] m_idle(input mdl_t m);
      return (m.owner < 0 && !m.gap) ? 32'd1 : 32'd0;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ma <= mreset();
         mb <= mreset();
      end else begin
         ma <= mstep(ma, {2'b00, req_a}, 2, 0);
         mb <= mstep(mb, req_b, 4, 4);
      end
   end

   always @(negedge clk) begin
      chk("a_grant",   32'(grant_a),   m_grant(ma));
      chk("a_lock_id", 32'(lock_id_a), m_id(ma));
      chk("a_idle",    32'(idle_a),    m_idle(ma));
      chk("a_timeout", 32'(timeout_a), 32'(ma.to));
      chk("b_grant",   32'(grant_b),   m_grant(mb));
      chk("b_lock_id", 32'(lock_id_b), m_id(mb));
      chk("b_idle",    32'(idle_b),    m_idle(mb));
      chk("b_timeout", 32'(timeout_b), 32'(mb.to));
      chk("b_onehot0", 32'($onehot0(grant_b)), 32'd1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic lita(input string tag, input int g, input int l, input int i, input int t);
      chk({tag, "_grant"},   32'(grant_a),   32'(g));
      chk({tag, "_lock_id"}, 32'(lock_id_a), 32'(l));
      chk({tag, "_idle"},    32'(idle_a),    32'(i));
      chk({tag, "_timeout"}, 32'(timeout_a), 32'(t));
   endtask

   task automatic litb(input string tag, input int g, input int l, input int i, input int t);
      chk({tag, "_grant"},   32'(grant_b),   32'(g));
      chk({tag, "_lock_id"}, 32'(lock_id_b), 32'(l));
      chk({tag, "_idle"},    32'(idle_b),    32'(i));
      chk({tag, "_timeout"}, 32'(timeout_b), 32'(t));
   endtask

   initial begin
      rst_n = 1'b0;
      req_a = 2'b11;
      req_b = 4'b1111;
      repeat (3) begin
         tick();
         lita("a_rst", 0, 0, 1, 0);
         litb("b_rst", 0, 0, 1, 0);
      end
      req_a = 2'b00;
      req_b = 4'b0000;
      rst_n = 1'b1;
      tick();
      lita("a_post_rst", 0, 0, 1, 0);

      // two-channel lock, ignored competitor, release gap, then hand-over
      req_a = 2'b01; tick(); lita("a_lock0", 1, 0, 0, 0);
      req_a = 2'b11; tick(); lita("a_hold0", 1, 0, 0, 0);
      tick();                lita("a_hold1", 1, 0, 0, 0);
      req_a = 2'b10; tick(); lita("a_release", 0, 0, 0, 0);
      tick();                lita("a_idle", 0, 0, 1, 0);
      tick();                lita("a_lock1", 2, 1, 0, 0);
      req_a = 2'b00; tick(); lita("a_release1", 0, 0, 0, 0);
      tick();                lita("a_idle1", 0, 0, 1, 0);

      // round-robin rotation under constant contention
      req_b = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         tick();
         litb("b_rr_grant", 1 << (k % 4), k % 4, 0, 0);
         req_b = 4'b1111 & ~(4'd1 << (k % 4));
         tick();
         litb("b_rr_release", 0, 0, 0, 0);
         req_b = 4'b1111;
         tick();
         litb("b_rr_idle", 0, 0, 1, 0);
      end

      // hold timeout, mask while still requesting, re-grant after a low pulse
      req_b = 4'b0001;
      repeat (4) begin
         tick();
         litb("b_to_hold", 1, 0, 0, 0);
      end
      tick(); litb("b_to_fire", 0, 0, 0, 1);
      tick(); litb("b_masked0", 0, 0, 1, 0);
      tick(); litb("b_masked1", 0, 0, 1, 0);
      req_b = 4'b0000; tick(); litb("b_unmask", 0, 0, 1, 0);
      req_b = 4'b0001; tick(); litb("b_regrant", 1, 0, 0, 0);

      // owner drops on the cycle the timeout would fire: plain release
      repeat (3) tick();
      litb("b_4th_cycle", 1, 0, 0, 0);
      req_b = 4'b0000; tick(); litb("b_drop_wins", 0, 0, 0, 0);
      tick();                  litb("b_drop_idle", 0, 0, 1, 0);
      req_b = 4'b0001; tick(); litb("b_drop_regrant", 1, 0, 0, 0);

      // asynchronous reset while channel 2 owns the lock
      req_b = 4'b0000; tick(); litb("b_pre_rst_rel", 0, 0, 0, 0);
      tick();                  litb("b_pre_rst_idle", 0, 0, 1, 0);
      req_b = 4'b0100; tick(); litb("b_lock2", 4, 2, 0, 0);
      #2 rst_n = 1'b0;
      #1;
      litb("b_async_rst", 0, 0, 1, 0);
      lita("a_async_rst", 0, 0, 1, 0);
      tick();
      litb("b_in_rst", 0, 0, 1, 0);
      req_b = 4'b1111;
      rst_n = 1'b1;
      tick();
      litb("b_ptr_cleared", 1, 0, 0, 0);
      req_b = 4'b0000;
      repeat (2) tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
